plm_port_scheduler: RTL and testbench

- Round-robin scheduler that shares the NBANKS x NPORTS private-local-memory (PLM) kernel ports among NCONSUMERS requesters.
- Each cycle it decodes each request's target bank and grants up to NPORTS requesters per bank, using a per-bank round-robin pointer.
- Granted accesses are registered onto the PLM kernel inputs.
- Read data coming back from the PLM is routed to the originating consumer using a tag pipeline.
- Sits between the consumer accelerators and the banked PLM.

---
 rtl/plm_port_scheduler.sv | 167 ++++++++++++++++
 tb/tb_plm_port_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/plm_port_scheduler.sv
// Round-robin scheduler sharing NBANKS x NPORTS PLM kernel ports among NCONSUMERS requesters.
// Optional per-consumer stall counters are enabled with the RR_SCHED_STATS_EN macro.
module plm_port_scheduler #(
  parameter int ADDR_WIDTH    = 4,
  parameter int VALUE_WIDTH   = 8,
  parameter int NCONSUMERS    = 2,
  parameter int NBANKS        = 1,
  parameter int NPORTS        = 2,
  parameter int COUNTER_WIDTH = 8,
  localparam int BANK_BITS       = $clog2(NBANKS),
  localparam int NKERNELS        = NBANKS * NPORTS,
  localparam int REQ_WIDTH       = ADDR_WIDTH + VALUE_WIDTH + 2,
  localparam int LOCAL_W         = ADDR_WIDTH - BANK_BITS,
  localparam int PLM_INPUT_WIDTH = LOCAL_W + VALUE_WIDTH + 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_ni,
  input  logic [NCONSUMERS*REQ_WIDTH-1:0]       requests_i,
  output logic [NCONSUMERS-1:0]                 grant_o,
  output logic [NKERNELS*PLM_INPUT_WIDTH-1:0]   out_o,
  output logic [NKERNELS-1:0]                   out_valid_o,
  input  logic [NKERNELS*VALUE_WIDTH-1:0]       plm_rdata_i,
  output logic [NCONSUMERS-1:0]                 resp_valid_o,
  output logic [NCONSUMERS*VALUE_WIDTH-1:0]     resp_data_o
`ifdef RR_SCHED_STATS_EN
  ,
  output logic [NCONSUMERS*COUNTER_WIDTH-1:0]   stall_count_o
`endif
);

  localparam int BANK_W = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ID_W   = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;

  logic [NCONSUMERS-1:0]                   req_valid;
  logic [NCONSUMERS-1:0]                   req_we;
  logic [NCONSUMERS-1:0][BANK_W-1:0]       req_bank;
  logic [NCONSUMERS-1:0][LOCAL_W-1:0]      req_local;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]  req_wdata;

  for (genvar c = 0; c < NCONSUMERS; c++) begin : g_decode
    localparam int BASE = c * REQ_WIDTH;
    assign req_valid[c] = requests_i[BASE+REQ_WIDTH-1];
    assign req_we[c]    = requests_i[BASE+REQ_WIDTH-2];
    assign req_wdata[c] = requests_i[BASE +: VALUE_WIDTH];
    if (NBANKS == 1) begin : g_one_bank
      assign req_bank[c]  = '0;
      assign req_local[c] = requests_i[BASE+VALUE_WIDTH +: ADDR_WIDTH];
    end else begin : g_multi_bank
      // Low address bits interleave consecutive words across banks.
      assign req_bank[c]  = requests_i[BASE+VALUE_WIDTH +: BANK_BITS];
      assign req_local[c] = requests_i[BASE+VALUE_WIDTH+BANK_BITS +: LOCAL_W];
    end
  end

  logic [NBANKS-1:0][ID_W-1:0]              rr_q, rr_d;
  logic [NCONSUMERS-1:0]                    grant_c;
  logic [NKERNELS-1:0]                      slot_valid, slot_rd;
  logic [NKERNELS-1:0][ID_W-1:0]            slot_id;
  logic [NKERNELS-1:0][PLM_INPUT_WIDTH-1:0] slot_data;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    int used;
    int idx;
    used       = 0;
    idx        = 0;
    grant_c    = '0;
    slot_valid = '0;
    slot_rd    = '0;
    slot_id    = '0;
    slot_data  = '0;
    rr_d       = rr_q;
    for (int b = 0; b < NBANKS; b++) begin
      used = 0;
      for (int i = 0; i < NCONSUMERS; i++) begin
        idx = int'(rr_q[b]) + i;
        if (idx >= NCONSUMERS) idx = idx - NCONSUMERS;
        for (int c = 0; c < NCONSUMERS; c++) begin
          if (c == idx && req_valid[c] && req_bank[c] == BANK_W'(b) && used < NPORTS) begin
            grant_c[c] = 1'b1;
            for (int p = 0; p < NPORTS; p++) begin
              if (p == used) begin
                slot_valid[b*NPORTS+p] = 1'b1;
                slot_rd[b*NPORTS+p]    = ~req_we[c];
                slot_id[b*NPORTS+p]    = ID_W'(c);
                slot_data[b*NPORTS+p]  = {req_local[c], req_wdata[c], req_we[c]};
              end
            end
            used    = used + 1;
            rr_d[b] = (c == NCONSUMERS - 1) ? '0 : ID_W'(c + 1);
          end
        end
      end
    end
  end

  assign grant_o = reset_ni ? grant_c : '0;

  logic [NKERNELS-1:0][PLM_INPUT_WIDTH-1:0] out_q;
  logic [NKERNELS-1:0]                      out_valid_q;
  logic [NKERNELS-1:0][ID_W-1:0]            tag_id_q;
  logic [NKERNELS-1:0]                      tag_rd_q;
  logic [NCONSUMERS-1:0]                    resp_valid_q, resp_valid_d;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]   resp_data_q, resp_data_d;

  // Each consumer owns at most one port per cycle, so at most one tag matches it.
  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    for (int k = 0; k < NKERNELS; k++) begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        if (tag_rd_q[k] && tag_id_q[k] == ID_W'(c)) begin
          resp_valid_d[c] = 1'b1;
          resp_data_d[c]  = plm_rdata_i[k*VALUE_WIDTH +: VALUE_WIDTH];
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_q        <= '0;
      out_valid_q  <= '0;
      tag_id_q     <= '0;
      tag_rd_q     <= '0;
      rr_q         <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      out_q        <= slot_data;
      out_valid_q  <= slot_valid;
      tag_id_q     <= slot_id;
      tag_rd_q     <= slot_rd;
      rr_q         <= rr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign out_o        = out_q;
  assign out_valid_o  = out_valid_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;

`ifdef RR_SCHED_STATS_EN
  logic [NCONSUMERS-1:0][COUNTER_WIDTH-1:0] stall_q;

  // Counters saturate at all-ones so long stalls stay visible.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_q <= '0;
    end else begin
      for (int c = 0; c < NCONSUMERS; c++) begin
        if (req_valid[c] && !grant_c[c] && stall_q[c] != {COUNTER_WIDTH{1'b1}}) begin
          stall_q[c] <= stall_q[c] + COUNTER_WIDTH'(1);
        end
      end
    end
  end

  assign stall_count_o = stall_q;
`else
  // Stall statistics are not built; no counter state exists.
`endif

endmodule

// File: tb/tb_plm_port_scheduler.sv
// Directed self-checking bench for plm_port_scheduler: default, single-port and two-bank instances.
// Stall-counter checks are compiled only when RR_SCHED_STATS_EN is defined.
module tb_plm_port_scheduler;

  logic        clk;
  logic        reset_n;

  // Instance a: defaults (1 bank, 2 ports)
  logic [27:0] req_a;
  logic [1:0]  grant_a;
  logic [25:0] out_a;
  logic [1:0]  out_valid_a;
  logic [15:0] plm_rdata_a;
  logic [1:0]  resp_valid_a;
  logic [15:0] resp_data_a;

  // Instance b: 1 bank, 1 port, 2-bit stall counters
  logic [27:0] req_b;
  logic [1:0]  grant_b;
  logic [12:0] out_b;
  logic        out_valid_b;
  logic [7:0]  plm_rdata_b;
  logic [1:0]  resp_valid_b;
  logic [15:0] resp_data_b;

  // Instance c: 2 banks, 1 port each
  logic [27:0] req_c;
  logic [1:0]  grant_c;
  logic [23:0] out_c;
  logic [1:0]  out_valid_c;
  logic [15:0] plm_rdata_c;
  logic [1:0]  resp_valid_c;
  logic [15:0] resp_data_c;

`ifdef RR_SCHED_STATS_EN
  logic [15:0] stall_a;
  logic [3:0]  stall_b;
  logic [15:0] stall_c;
`endif

  int vectors     = 0;
  int miscompares = 0;

  plm_port_scheduler u_dut (
    .clk_i(clk), .reset_ni(reset_n), .requests_i(req_a), .grant_o(grant_a),
    .out_o(out_a), .out_valid_o(out_valid_a), .plm_rdata_i(plm_rdata_a),
    .resp_valid_o(resp_valid_a), .resp_data_o(resp_data_a)
`ifdef RR_SCHED_STATS_EN
    , .stall_count_o(stall_a)
`endif
  );

  plm_port_scheduler #(.NPORTS(1), .COUNTER_WIDTH(2)) u_np1 (
    .clk_i(clk), .reset_ni(reset_n), .requests_i(req_b), .grant_o(grant_b),
    .out_o(out_b), .out_valid_o(out_valid_b), .plm_rdata_i(plm_rdata_b),
    .resp_valid_o(resp_valid_b), .resp_data_o(resp_data_b)
`ifdef RR_SCHED_STATS_EN
    , .stall_count_o(stall_b)
`endif
  );

  plm_port_scheduler #(.NBANKS(2), .NPORTS(1)) u_nb2 (
    .clk_i(clk), .reset_ni(reset_n), .requests_i(req_c), .grant_o(grant_c),
    .out_o(out_c), .out_valid_o(out_valid_c), .plm_rdata_i(plm_rdata_c),
    .resp_valid_o(resp_valid_c), .resp_data_o(resp_data_c)
`ifdef RR_SCHED_STATS_EN
    , .stall_count_o(stall_c)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [13:0] mk_req(input logic we, input logic [3:0] addr,
                                         input logic [7:0] wdata);
    return {1'b1, we, addr, wdata};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // NOTE: stimulus is driven with blocking assignments away from the clock edge.
    reset_n     = 1'b1;
    req_a       = '0;
    req_b       = '0;
    req_c       = '0;
    plm_rdata_a = '0;
    plm_rdata_b = '0;
    plm_rdata_c = '0;

    // Reset asserted at t=5, released at t=20
    #5  reset_n = 1'b0;
    #15 reset_n = 1'b1;
    #2;
    check("rst_out_a",        32'(out_a),        32'h0);
    check("rst_out_valid_a",  32'(out_valid_a),  32'h0);
    check("rst_grant_a",      32'(grant_a),      32'h0);
    check("rst_resp_valid_a", 32'(resp_valid_a), 32'h0);
    check("rst_out_valid_b",  32'(out_valid_b),  32'h0);
    check("rst_out_valid_c",  32'(out_valid_c),  32'h0);

    // No contention: c0 writes 0xA5 to addr 3, c1 reads addr 5
    req_a = {mk_req(1'b0, 4'd5, 8'h00), mk_req(1'b1, 4'd3, 8'hA5)};
    #1;
    check("nc_grant", 32'(grant_a), 32'h3);
    tick();
    check("nc_out_valid", 32'(out_valid_a),   32'h3);
    check("nc_out0",      32'(out_a[12:0]),   32'h74B);
    check("nc_out1",      32'(out_a[25:13]),  32'hA00);
    check("nc_resp_early", 32'(resp_valid_a), 32'h0);
    req_a       = '0;
    plm_rdata_a = 16'h3C00;
    tick();
    check("nc_resp_valid", 32'(resp_valid_a),      32'h2);
    check("nc_resp_data1", 32'(resp_data_a[15:8]), 32'h3C);
    plm_rdata_a = '0;
    tick();
    check("nc_resp_drop",  32'(resp_valid_a),      32'h0);
    check("nc_resp_hold",  32'(resp_data_a[15:8]), 32'h3C);

    // Single port contention: c0 reads addr 1, c1 reads addr 2, both continuously
    req_b       = {mk_req(1'b0, 4'd2, 8'h00), mk_req(1'b0, 4'd1, 8'h00)};
    plm_rdata_b = 8'h5A;
    #1;
    check("np1_grant_first", 32'(grant_b), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("np1_out_valid", 32'(out_valid_b), 32'h1);
      check("np1_out",       32'(out_b),       (i % 2 == 0) ? 32'h200 : 32'h400);
      check("np1_grant",     32'(grant_b),     (i % 2 == 0) ? 32'h2 : 32'h1);
      if (i > 0) check("np1_resp_id", 32'(resp_valid_b), (i % 2 == 1) ? 32'h1 : 32'h2);
    end
    req_b       = '0;
    plm_rdata_b = '0;

    // Two banks: c0 addr 4 (bank 0), c1 addr 7 (bank 1)
    req_c = {mk_req(1'b0, 4'd7, 8'h00), mk_req(1'b0, 4'd4, 8'h00)};
    #1;
    check("nb2_grant", 32'(grant_c), 32'h3);
    tick();
    check("nb2_out_valid", 32'(out_valid_c),  32'h3);
    check("nb2_out0",      32'(out_c[11:0]),  32'h400);
    check("nb2_out1",      32'(out_c[23:12]), 32'h600);
    req_c = '0;

    // Mid-read reset: c1 reads addr 5, reset lands the cycle after the grant
    tick();
    req_a = {mk_req(1'b0, 4'd5, 8'h00), 14'h0};
    #1;
    check("mr_grant", 32'(grant_a), 32'h2);
    tick();
    check("mr_out_valid", 32'(out_valid_a),  32'h1);
    check("mr_out0",      32'(out_a[12:0]),  32'hA00);
    reset_n = 1'b0;
    #1;
    check("mr_async_out_valid", 32'(out_valid_a), 32'h0);
    check("mr_async_out",       32'(out_a),       32'h0);
    check("mr_grant_in_reset",  32'(grant_a),     32'h0);
    tick();
    reset_n     = 1'b1;
    req_a       = '0;
    plm_rdata_a = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_resp", 32'(resp_valid_a), 32'h0);
    end
    plm_rdata_a = '0;

`ifdef RR_SCHED_STATS_EN
    // Saturating stall counter: c1 loses every other cycle, 2-bit counter tops out at 3
    check("st_reset", 32'(stall_b), 32'h0);
    req_b = {mk_req(1'b0, 4'd2, 8'h00), mk_req(1'b0, 4'd1, 8'h00)};
    for (int n = 1; n <= 10; n++) begin
      tick();
      check("st_count1", 32'(stall_b[3:2]), ((n + 1) / 2 > 3) ? 32'd3 : 32'((n + 1) / 2));
    end
    check("st_count0", 32'(stall_b[1:0]), 32'd3);
    req_b = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
